// File: rtl/rtp_pkg.sv
// Shared types and constants for the ray-data fetch path.
// Holds the default widths, the ray field index map (field 0 in the LSBs),
// the packed ray record and the fetch controller state encoding.
package rtp_pkg;

  localparam int unsigned RAY_ADDR_W = 10;
  localparam int unsigned RAY_DATA_W = 32;
  localparam int unsigned NFIELD     = 13;

  localparam int unsigned FLD_ORIGX = 0;
  localparam int unsigned FLD_ORIGY = 1;
  localparam int unsigned FLD_ORIGZ = 2;
  localparam int unsigned FLD_DIRX  = 3;
  localparam int unsigned FLD_DIRY  = 4;
  localparam int unsigned FLD_DIRZ  = 5;
  localparam int unsigned FLD_HITT  = 6;
  localparam int unsigned FLD_IDIRX = 7;
  localparam int unsigned FLD_IDIRY = 8;
  localparam int unsigned FLD_IDIRZ = 9;
  localparam int unsigned FLD_OODX  = 10;
  localparam int unsigned FLD_OODY  = 11;
  localparam int unsigned FLD_OODZ  = 12;

  // Declared MSB-first so that origx lands in the least significant word.
  typedef struct packed {
    logic [RAY_DATA_W-1:0] oodz;
    logic [RAY_DATA_W-1:0] oody;
    logic [RAY_DATA_W-1:0] oodx;
    logic [RAY_DATA_W-1:0] idirz;
    logic [RAY_DATA_W-1:0] idiry;
    logic [RAY_DATA_W-1:0] idirx;
    logic [RAY_DATA_W-1:0] hitt;
    logic [RAY_DATA_W-1:0] dirz;
    logic [RAY_DATA_W-1:0] diry;
    logic [RAY_DATA_W-1:0] dirx;
    logic [RAY_DATA_W-1:0] origz;
    logic [RAY_DATA_W-1:0] origy;
    logic [RAY_DATA_W-1:0] origx;
  } ray_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ray_fetch_fifo.sv
// Two-entry output buffer for fetched ray records.
// Ports: clock, reset (sync, active-low), push/push_data write side,
// pop (caller guarantees non-empty), head = oldest entry, count = occupancy.
// Push and pop in the same cycle are both honoured.
module ray_fetch_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ray_fetch.sv
// Sequential reader for the ray-data RAMs.
// A start pulse latches base/count; rays base..base+count-1 (wrapping) are
// read over the shared RAM port and streamed out on a valid/ready interface.
// Ports: clock, reset (sync, active-low); io_start/io_base/io_count command;
// io_busy/io_done status; io_ram_rdEn/rdAddr/rdData RAM read port (1-cycle
// latency); io_ray_valid/ready/data/id output stream.
module ray_fetch #(
  parameter int unsigned ADDR_W = rtp_pkg::RAY_ADDR_W,
  parameter int unsigned DATA_W = rtp_pkg::RAY_DATA_W,
  parameter int unsigned NFIELD = rtp_pkg::NFIELD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_start,
  input  logic [ADDR_W-1:0]        io_base,
  input  logic [ADDR_W:0]          io_count,
  output logic                     io_busy,
  output logic                     io_done,
  output logic                     io_ram_rdEn,
  output logic [ADDR_W-1:0]        io_ram_rdAddr,
  input  logic [NFIELD*DATA_W-1:0] io_ram_rdData,
  output logic                     io_ray_valid,
  input  logic                     io_ray_ready,
  output logic [NFIELD*DATA_W-1:0] io_ray_data,
  output logic [ADDR_W-1:0]        io_ray_id
);

  import rtp_pkg::*;

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RAY_W = NFIELD * DATA_W;
  localparam int unsigned ENT_W = RAY_W + ADDR_W;

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  accepted_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              pop_c;
  logic              credit_c;
  logic              last_pop_c;
  logic [1:0]        occ;
  logic [ENT_W-1:0]  head;

  assign pop_c      = (occ != 2'd0) && io_ray_ready;
  // Buffered + in-flight rays must stay below two after this cycle's pop.
  assign credit_c   = (3'(occ) + 3'(pend_q)) < (3'd2 + 3'(pop_c));
  assign last_pop_c = (accepted_q + CNT_W'(pop_c)) == count_q;
  assign rd_addr_c  = rd_en_c ? ADDR_W'(base_q + issued_q[ADDR_W-1:0]) : '0;

  // Next-state and read issue.
  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    case (state_q)
      // A zero-length request still spends one busy cycle before done.
      IDLE:  if (io_start) state_d = (io_count == '0) ? DRAIN : FETCH;
      FETCH: begin
        if (issued_q == count_q) state_d = DRAIN;
        else if (credit_c)       rd_en_c = 1'b1;
      end
      DRAIN: if (last_pop_c) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, command latch, progress counters and read-latency tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= rd_en_c;
      pend_addr_q <= rd_addr_c;
      if ((state_q == IDLE) && io_start) begin
        base_q     <= io_base;
        count_q    <= io_count;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (rd_en_c) issued_q   <= issued_q + CNT_W'(1);
        if (pop_c)   accepted_q <= accepted_q + CNT_W'(1);
      end
    end
  end

  ray_fetch_fifo #(
    .WIDTH(ENT_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pend_q),
    .push_data({pend_addr_q, io_ram_rdData}),
    .pop      (pop_c),
    .head     (head),
    .count    (occ)
  );

  assign io_busy       = (state_q == FETCH) || (state_q == DRAIN);
  assign io_done       = (state_q == DONE);
  assign io_ram_rdEn   = rd_en_c;
  assign io_ram_rdAddr = rd_addr_c;
  assign io_ray_valid  = (occ != 2'd0);
  assign io_ray_id     = head[ENT_W-1:RAY_W];
  assign io_ray_data   = head[RAY_W-1:0];

endmodule

// File: tb/tb_ray_fetch.sv
// Self-checking bench for ray_fetch with a behavioural ray RAM and a
// scoreboard of expected ray ids / read addresses.
module tb_ray_fetch;

  import rtp_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = NFIELD * DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          io_start = 1'b0;
  logic [AW-1:0] io_base = '0;
  logic [AW:0]   io_count = '0;
  logic          io_busy;
  logic          io_done;
  logic          io_ram_rdEn;
  logic [AW-1:0] io_ram_rdAddr;
  logic [RW-1:0] io_ram_rdData = '0;
  logic          io_ray_valid;
  logic          io_ray_ready = 1'b0;
  logic [RW-1:0] io_ray_data;
  logic [AW-1:0] io_ray_id;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] id_q[$];
  logic [AW-1:0] addr_q[$];

  ray_fetch #(.ADDR_W(AW), .DATA_W(DW), .NFIELD(NFIELD)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_base      (io_base),
    .io_count     (io_count),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_ram_rdEn  (io_ram_rdEn),
    .io_ram_rdAddr(io_ram_rdAddr),
    .io_ram_rdData(io_ram_rdData),
    .io_ray_valid (io_ray_valid),
    .io_ray_ready (io_ray_ready),
    .io_ray_data  (io_ray_data),
    .io_ray_id    (io_ray_id)
  );

  always #5 clock = ~clock;

  // Ray k holds field value k*16+f in field f.
  function automatic logic [RW-1:0] mk_ray(input logic [AW-1:0] k);
    logic [RW-1:0] r;
    r = '0;
    for (int f = 0; f < int'(NFIELD); f++) r[f*DW +: DW] = DW'(int'(k) * 16 + f);
    return r;
  endfunction

  // Behavioural synchronous RAM, one cycle read latency.
  always @(posedge clock) if (io_ram_rdEn) io_ram_rdData <= mk_ray(io_ram_rdAddr);

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    io_base  = b;
    io_count = n;
    io_start = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      id_q.push_back(AW'(int'(b) + i));
      addr_q.push_back(AW'(int'(b) + i));
    end
    @(negedge clock);
    io_start = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
  // poke: cycle in which a conflicting start (base 100) is pulsed, 0 = none.
  task automatic run_stream(input int mode, input int poke, output int first_v, output int done_c);
    int            occ;
    int            infl;
    int            pop;
    logic          hold;
    logic [RW-1:0] hd;
    logic [AW-1:0] hid;
    logic          done_seen;
    logic [AW-1:0] e;
    occ = 0; infl = 0; hold = 1'b0; hd = '0; hid = '0; done_seen = 1'b0;
    first_v = -1; done_c = -1;
    for (int cyc = 1; cyc <= 4000 && !done_seen; cyc++) begin
      case (mode)
        0:       io_ray_ready = 1'b1;
        1:       io_ray_ready = (cyc % 3 == 1);
        default: io_ray_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == poke) begin
        io_start = 1'b1; io_base = AW'(100); io_count = (AW+1)'(7);
      end else begin
        io_start = 1'b0;
      end
      #1;
      pop = (io_ray_valid && io_ray_ready) ? 1 : 0;
      if (hold) begin
        checks++;
        if (io_ray_valid !== 1'b1 || io_ray_data !== hd || io_ray_id !== hid) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d: valid=%b id=%0d, required valid=1 id=%0d data unchanged", cyc, io_ray_valid, io_ray_id, hid);
        end
      end
      checks++;
      if (io_ray_valid !== (occ != 0)) begin
        errors++;
        $display("FAIL valid_occ cyc=%0d: valid=%b, required %b", cyc, io_ray_valid, occ != 0);
      end
      if (io_ram_rdEn) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_extra cyc=%0d: rdAddr=%0d, required no read", cyc, io_ram_rdAddr);
        end else begin
          e = addr_q.pop_front();
          if (io_ram_rdAddr !== e) begin
            errors++;
            $display("FAIL rd_addr cyc=%0d: rdAddr=%0d, required %0d", cyc, io_ram_rdAddr, e);
          end
        end
        checks++;
        if (occ + infl - pop >= 2) begin
          errors++;
          $display("FAIL credit cyc=%0d: read issued with occ=%0d inflight=%0d pop=%0d, required total<2", cyc, occ, infl, pop);
        end
      end
      if (pop != 0) begin
        if (first_v < 0) first_v = cyc;
        checks++;
        if (id_q.size() == 0) begin
          errors++;
          $display("FAIL ray_extra cyc=%0d: id=%0d, required no ray", cyc, io_ray_id);
        end else begin
          e = id_q.pop_front();
          if (io_ray_id !== e || io_ray_data !== mk_ray(e)) begin
            errors++;
            $display("FAIL ray cyc=%0d: id=%0d data=%h, required id=%0d data=%h", cyc, io_ray_id, io_ray_data, e, mk_ray(e));
          end
        end
      end
      checks++;
      if (io_done) begin
        if (pop != 0 || id_q.size() != 0 || io_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_early cyc=%0d: pop=%0d pending=%0d busy=%b, required 0/0/0", cyc, pop, id_q.size(), io_busy);
        end
        done_c = cyc;
        done_seen = 1'b1;
      end else if (io_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_run cyc=%0d: busy=%b, required 1", cyc, io_busy);
      end
      hold = io_ray_valid && !io_ray_ready;
      hd   = io_ray_data;
      hid  = io_ray_id;
      occ  = occ + infl - pop;
      infl = io_ram_rdEn ? 1 : 0;
      @(negedge clock);
    end
    io_start = 1'b0;
    if (!done_seen) begin
      errors++;
      $display("FAIL timeout: no done pulse, required one");
    end
    #1;
    checks++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b, required 0/0", io_done, io_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; io_start = 1'b0; io_ray_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({io_busy, io_done, io_ram_rdEn, io_ray_valid} !== 4'b0 || io_ram_rdAddr !== '0 ||
        io_ray_id !== '0 || io_ray_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rdEn=%b valid=%b, required all 0", io_busy, io_done, io_ram_rdEn, io_ray_valid);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int fv, dc;
    do_start(AW'(0), (AW+1)'(3));
    run_stream(0, 0, fv, dc);
    checks++;
    if (fv != 3 || dc != 6) begin
      errors++;
      $display("FAIL basic_timing: first_valid=%0d done=%0d, required 3/6", fv, dc);
    end
  endtask

  task automatic test_backpressure();
    int fv, dc;
    do_start(AW'(40), (AW+1)'(4));
    run_stream(1, 0, fv, dc);
    checks++;
    if (fv != 4) begin
      errors++;
      $display("FAIL bp_first: first accept=%0d, required 4", fv);
    end
  endtask

  task automatic test_zero_count();
    do_start(AW'(7), (AW+1)'(0));
    #1;
    checks++;
    if (io_busy !== 1'b1 || io_done !== 1'b0 || io_ram_rdEn !== 1'b0) begin
      errors++;
      $display("FAIL zero_t1: busy=%b done=%b rdEn=%b, required 1/0/0", io_busy, io_done, io_ram_rdEn);
    end
    @(negedge clock); #1;
    checks++;
    if (io_busy !== 1'b0 || io_done !== 1'b1 || io_ram_rdEn !== 1'b0) begin
      errors++;
      $display("FAIL zero_t2: busy=%b done=%b rdEn=%b, required 0/1/0", io_busy, io_done, io_ram_rdEn);
    end
    @(negedge clock); #1;
    checks++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_t3: done=%b busy=%b, required 0/0", io_done, io_busy);
    end
  endtask

  task automatic test_wrap();
    int fv, dc;
    do_start(AW'(1022), (AW+1)'(4));
    run_stream(2, 0, fv, dc);
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_reads: %0d reads missing, required 0", addr_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int fv, dc;
    do_start(AW'(5), (AW+1)'(4));
    run_stream(0, 2, fv, dc);
    checks++;
    if (dc != 7) begin
      errors++;
      $display("FAIL busy_start_done: done=%0d, required 7", dc);
    end
  endtask

  task automatic test_full_sweep();
    int fv, dc;
    do_start(AW'(512), (AW+1)'(1024));
    run_stream(0, 0, fv, dc);
    checks++;
    if (fv != 3 || dc != 1027) begin
      errors++;
      $display("FAIL sweep_timing: first_valid=%0d done=%0d, required 3/1027", fv, dc);
    end
  endtask

  task automatic test_reset_mid_run();
    int            acc;
    int            fv, dc;
    logic [AW-1:0] e;
    logic          done_bad;
    acc = 0;
    do_start(AW'(50), (AW+1)'(6));
    io_ray_ready = 1'b1;
    for (int cyc = 1; cyc <= 20 && acc < 2; cyc++) begin
      #1;
      if (io_ray_valid && io_ray_ready) begin
        e = id_q.pop_front();
        checks++;
        if (io_ray_id !== e) begin
          errors++;
          $display("FAIL rst_pre_ray: id=%0d, required %0d", io_ray_id, e);
        end
        acc++;
      end
      @(negedge clock);
    end
    checks++;
    if (acc != 2) begin
      errors++;
      $display("FAIL rst_pre_timeout: accepted=%0d, required 2", acc);
    end
    reset = 1'b0; io_ray_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (io_ray_valid !== 1'b0 || io_busy !== 1'b0 || io_done !== 1'b0 || io_ram_rdEn !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: valid=%b busy=%b done=%b rdEn=%b, required all 0", io_ray_valid, io_busy, io_done, io_ram_rdEn);
    end
    id_q.delete();
    addr_q.delete();
    done_bad = 1'b0;
    repeat (5) begin
      @(negedge clock); #1;
      if (io_done !== 1'b0 || io_ray_valid !== 1'b0) done_bad = 1'b1;
    end
    checks++;
    if (done_bad) begin
      errors++;
      $display("FAIL rst_quiet: done or valid seen after abort, required none");
    end
    do_start(AW'(300), (AW+1)'(3));
    run_stream(0, 0, fv, dc);
    checks++;
    if (fv != 3 || dc != 6) begin
      errors++;
      $display("FAIL rst_restart: first_valid=%0d done=%0d, required 3/6", fv, dc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    test_full_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
